md_scheduler: RTL

Sequencing controller for the multiply/divide unit and the HI/LO register pair in the pipelined CPU. Accepts multiply/divide/move-to-HI/LO operations from the execute stage, runs them for a fixed multi-cycle latency, commits results to HI/LO, and raises the decode-stage stall while the unit is occupied. Its HiDataE/LoDataE outputs feed the E/M pipeline register alongside ALUOutE.

---
 rtl/md_scheduler_if.sv | 32 +++
 rtl/md_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler_if.sv
// rtl/md_scheduler_if.sv - execute-stage <-> multiply/divide scheduler bundle (FlushMD only with MD_FLUSH_EN)
interface md_scheduler_if;
  logic [2:0]  MDOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        MDUseD;
`ifdef MD_FLUSH_EN
  logic        FlushMD;
`endif
  logic        BusyE;
  logic        StallMD;
  logic [31:0] HiDataE;
  logic [31:0] LoDataE;

  // Pipeline side: issues operations and observes HI/LO and the stall
  modport master (
`ifdef MD_FLUSH_EN
    output FlushMD,
`endif
    output MDOpE, SrcAE, SrcBE, MDUseD,
    input  BusyE, StallMD, HiDataE, LoDataE
  );

  // Scheduler side
  modport slave (
`ifdef MD_FLUSH_EN
    input  FlushMD,
`endif
    input  MDOpE, SrcAE, SrcBE, MDUseD,
    output BusyE, StallMD, HiDataE, LoDataE
  );
endinterface

// File: rtl/md_scheduler.sv
// rtl/md_scheduler.sv - multiply/divide sequencer owning HI/LO, optional abort via MD_FLUSH_EN
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_scheduler_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      phi_q, phi_d;
  logic [31:0]      plo_q, plo_d;

  logic        is_start;
  logic        is_mult;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               div_by_zero;
  logic               div_overflow;

  // Multi-cycle ops are 001..100; reserved 111 falls out as "none"
  assign is_start = (md.MDOpE != 3'b000) && (md.MDOpE <= OP_DIVU);
  assign is_mult  = (md.MDOpE == OP_MULT) || (md.MDOpE == OP_MULTU);

  assign a_s = $signed(md.SrcAE);
  assign b_s = $signed(md.SrcBE);

  // Full 64-bit products; operands widened so no bits are lost
  assign prod_s = $signed({{32{md.SrcAE[31]}}, md.SrcAE}) * $signed({{32{md.SrcBE[31]}}, md.SrcBE});
  assign prod_u = {32'd0, md.SrcAE} * {32'd0, md.SrcBE};

  // Signed divide truncates toward zero with remainder taking the dividend's sign
  assign quot_s = a_s / b_s;
  assign rem_s  = a_s % b_s;
  assign quot_u = md.SrcAE / md.SrcBE;
  assign rem_u  = md.SrcAE % md.SrcBE;

  assign div_by_zero  = (md.SrcBE == 32'd0);
  assign div_overflow = (md.SrcAE == 32'h8000_0000) && (md.SrcBE == 32'hFFFF_FFFF);

  // Select the 64-bit result the started op will eventually commit
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md.MDOpE)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (div_by_zero) begin
          res_hi = md.SrcAE;
          res_lo = 32'hFFFF_FFFF;
        end else if (div_overflow) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      OP_DIVU: begin
        if (div_by_zero) begin
          res_hi = md.SrcAE;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  // Next-state: launch from IDLE, count down in BUSY, commit on the last busy cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      IDLE: begin
        if (is_start) begin
          phi_d   = res_hi;
          plo_d   = res_lo;
          cnt_d   = is_mult ? MULT_N : DIV_N;
          state_d = BUSY;
        end else if (md.MDOpE == OP_MTHI) begin
          hi_d = md.SrcAE;
        end else if (md.MDOpE == OP_MTLO) begin
          lo_d = md.SrcAE;
        end
      end
      BUSY: begin
        // New ops are dropped here; the hazard unit keeps them from arriving
        if (cnt_q == CNT_ONE) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    endcase
`ifdef MD_FLUSH_EN
    // Abort wins over everything, including a same-cycle commit or launch
    if (md.FlushMD) begin
      state_d = IDLE;
      cnt_d   = '0;
      phi_d   = 32'd0;
      plo_d   = 32'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
`endif
  end

  // State and data registers; reset drops any pending result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign md.BusyE   = (state_q == BUSY);
  // Only combinational input-to-output path: a D-stage HI/LO user stalls on a busy or launching unit
  assign md.StallMD = md.MDUseD & (md.BusyE | is_start);
  assign md.HiDataE = hi_q;
  assign md.LoDataE = lo_q;

endmodule
